sdram_upload_reader: RTL

- Read-side counterpart of the download loader: while the IO controller runs an upload (`ioctl_upload`), it fetches bytes from SDRAM and presents them on `ioctl_din` to data_io.
- SDRAM accesses are issued only in loader slots aligned to `mem_sync`, exactly as the download path issues writes.
- The top-level mux gives `rd_adr` priority on `sdram_adr` whenever `rd_req` is high.
- Index 8'hFF (CMOS) is never read from SDRAM; that index is served elsewhere.

---
 rtl/sdram_upload_reader_pkg.sv | 16 +
 rtl/sdram_upload_reader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sdram_upload_reader_pkg.sv
// Shared definitions for the SDRAM loader paths: FSM states and address map.
package upload_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT,
        HOLD
    } state_t;

    localparam logic [24:0] BASE_ROM   = 25'h80000;
    localparam logic [24:0] BASE_OTHER = 25'h68000;
    localparam logic [24:0] MAX_LEN    = 25'h40000;
    localparam logic [7:0]  CMOS_INDEX = 8'hFF;

endpackage

// File: rtl/sdram_upload_reader.sv
// Upload read path: fetches bytes from SDRAM in mem_sync-aligned slots and
// presents them to data_io while an upload is in progress.
module sdram_upload_reader
    import upload_pkg::*;
#(
    parameter int unsigned      AW         = 25,
    parameter logic [AW-1:0]    BASE_ROM   = upload_pkg::BASE_ROM,
    parameter logic [AW-1:0]    BASE_OTHER = upload_pkg::BASE_OTHER,
    parameter logic [AW-1:0]    MAX_LEN    = upload_pkg::MAX_LEN
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          mem_sync,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic [AW-1:0] ioctl_addr,
    input  logic          ioctl_rd,
    output logic [7:0]    ioctl_din,
    output logic          din_valid,
    output logic          rd_req,
    output logic [AW-1:0] rd_adr,
    input  logic [7:0]    sdram_do
);

    state_t        r_state,   w_state_nxt;
    logic          r_pending, w_pending_nxt;
    logic          r_en_d;
    logic [7:0]    r_din,     w_din_nxt;
    logic          r_valid,   w_valid_nxt;
    logic          r_req,     w_req_nxt;
    logic [AW-1:0] r_adr,     w_adr_nxt;

    logic          w_en;
    logic          w_oob;
    logic          w_restart;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_adr;

    assign w_en   = ioctl_upload && (ioctl_index != CMOS_INDEX);
    assign w_base = (ioctl_index == 8'h00) ? BASE_ROM : BASE_OTHER;
    assign w_adr  = w_base + ioctl_addr;
    assign w_oob  = (ioctl_addr >= MAX_LEN);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_en_d    <= 1'b0;
            r_din     <= 8'h00;
            r_valid   <= 1'b0;
            r_req     <= 1'b0;
            r_adr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_en_d    <= w_en;
            r_din     <= w_din_nxt;
            r_valid   <= w_valid_nxt;
            r_req     <= w_req_nxt;
            r_adr     <= w_adr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_din_nxt     = r_din;
        w_valid_nxt   = r_valid;
        w_req_nxt     = r_req;
        w_adr_nxt     = r_adr;
        w_restart     = 1'b0;

        if (!w_en) begin
            w_state_nxt   = IDLE;
            w_pending_nxt = 1'b0;
            w_valid_nxt   = 1'b0;
            w_req_nxt     = 1'b0;
            w_adr_nxt     = '0;
        end else begin
            case (r_state)
                IDLE: w_restart = !r_en_d || ioctl_rd;
                ARM: begin
                    if (mem_sync) begin
                        w_adr_nxt   = w_adr;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (ioctl_rd)
                        w_pending_nxt = 1'b1;
                    if (mem_sync) begin
                        w_req_nxt = 1'b0;
                        w_din_nxt = sdram_do;
                        // A consumed byte mid-read makes this capture stale: refetch.
                        if (r_pending || ioctl_rd) begin
                            w_pending_nxt = 1'b0;
                            w_restart     = 1'b1;
                        end else begin
                            w_valid_nxt = 1'b1;
                            w_state_nxt = HOLD;
                        end
                    end
                end
                HOLD: w_restart = ioctl_rd;
                default: w_state_nxt = IDLE;
            endcase

            if (w_restart) begin
                w_valid_nxt = 1'b0;
                if (w_oob) begin
                    w_din_nxt   = 8'hFF;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = ARM;
                end
            end
        end
    end

    assign ioctl_din = r_din;
    assign din_valid = r_valid && w_en && !ioctl_rd;
    assign rd_req    = r_req;
    assign rd_adr    = r_adr;

endmodule
